// File: rtl/vga_frame_display.sv
// 256x128 1-bit frame buffer scanned out as 640x480@60 VGA with 4x4 pixel replication.
// Define VGA_BORDER_EN to paint the outermost visible cells in the foreground colour.
module vga_frame_display #(
   parameter int unsigned TICK_DIV     = 4,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_DISP_START = 144,
   parameter int unsigned H_DISP_END   = 784,
   parameter int unsigned H_TOTAL      = 800,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_DISP_START = 31,
   parameter int unsigned V_DISP_END   = 511,
   parameter int unsigned V_TOTAL      = 521
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [14:0] A_ADDR,
   input  logic        A_DATA_IN,
   input  logic        A_WE,
   output logic        A_DATA_OUT,
   input  logic [15:0] CONFIG_COLOURS,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic [7:0]  VGA_COLOUR,
   output logic        FRAME_START
);

   localparam int unsigned CNT_W     = 10;
   localparam int unsigned DIV_W     = $clog2(TICK_DIV);
   localparam int unsigned MEM_DEPTH = 32768;

   logic             mem [MEM_DEPTH];
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             t1_q;
   logic             t2_q;

   logic             tick_c;
   logic             line_end_c;
   logic             frame_end_c;
   logic             hs_n_c;
   logic             vs_n_c;
   logic             vis_c;
   logic             border_c;
   logic [CNT_W-1:0] hx_c;
   logic [CNT_W-1:0] vy_c;
   logic [7:0]       cell_x_c;
   logic [6:0]       cell_y_c;
   logic [14:0]      rd_addr_c;

   logic             pix_q;
   logic             hs1_q;
   logic             vs1_q;
   logic             vis1_q;
   logic             border1_q;

   assign tick_c      = (div_q == DIV_W'(TICK_DIV - 1));
   assign line_end_c  = (hcount == CNT_W'(H_TOTAL - 1));
   assign frame_end_c = (vcount == CNT_W'(V_TOTAL - 1));

   // Pixel-tick divider, raster counters and the tick-delay strobes that step the pipeline
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         div_q  <= '0;
         hcount <= '0;
         vcount <= '0;
         t1_q   <= 1'b0;
         t2_q   <= 1'b0;
      end else begin
         t1_q <= tick_c;
         t2_q <= t1_q;
         if (tick_c) begin
            div_q <= '0;
            if (line_end_c) begin
               hcount <= '0;
               vcount <= frame_end_c ? '0 : vcount + CNT_W'(1);
            end else begin
               hcount <= hcount + CNT_W'(1);
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   always_comb begin
      hs_n_c    = (hcount >= CNT_W'(H_SYNC));
      vs_n_c    = (vcount >= CNT_W'(V_SYNC));
      vis_c     = (hcount >= CNT_W'(H_DISP_START)) && (hcount < CNT_W'(H_DISP_END)) &&
                  (vcount >= CNT_W'(V_DISP_START)) && (vcount < CNT_W'(V_DISP_END));
      hx_c      = hcount - CNT_W'(H_DISP_START);
      vy_c      = vcount - CNT_W'(V_DISP_START);
      cell_x_c  = 8'(hx_c >> 2);
      cell_y_c  = 7'(vy_c >> 2);
      rd_addr_c = {cell_y_c, cell_x_c};
`ifdef VGA_BORDER_EN
      border_c  = (cell_x_c == 8'd0) || (cell_x_c == 8'd159) ||
                  (cell_y_c == 7'd0) || (cell_y_c == 7'd119);
`else
      border_c  = 1'b0;
`endif
   end

   // Port A write; scan and port-A reads see the pre-write contents
   always_ff @(posedge CLK) begin
      if (A_WE) mem[A_ADDR] <= A_DATA_IN;
   end

   always_ff @(posedge CLK) begin
      if (t1_q) pix_q <= mem[rd_addr_c];
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) A_DATA_OUT <= 1'b0;
      else       A_DATA_OUT <= mem[A_ADDR];
   end

   // Stage 1: timing flags travel alongside the buffer read
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
         vis1_q    <= 1'b0;
         border1_q <= 1'b0;
      end else if (t1_q) begin
         hs1_q     <= hs_n_c;
         vs1_q     <= vs_n_c;
         vis1_q    <= vis_c;
         border1_q <= border_c;
      end
   end

   // Stage 2: colour mapping and aligned sync outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         VGA_HS     <= 1'b1;
         VGA_VS     <= 1'b1;
         VGA_COLOUR <= 8'h00;
      end else if (t2_q) begin
         VGA_HS     <= hs1_q;
         VGA_VS     <= vs1_q;
         VGA_COLOUR <= !vis1_q ? 8'h00 :
                       (pix_q || border1_q) ? CONFIG_COLOURS[15:8] : CONFIG_COLOURS[7:0];
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) FRAME_START <= 1'b0;
      else       FRAME_START <= tick_c && line_end_c && frame_end_c;
   end

endmodule

// File: tb/tb_vga_frame_display.sv
// Randomized bench for vga_frame_display: compact raster, cycle-count-based reference model.
module tb_vga_frame_display;

   localparam int HT = 56, HSY = 8, HDS = 12, HDE = 52;
   localparam int VT = 29, VSY = 2, VDS = 3, VDE = 27;
   localparam int FRAME_TICKS = HT * VT;
   localparam int FRAME_CYC   = 4 * FRAME_TICKS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [14:0] a_addr = '0;
   logic        a_din = 1'b0;
   logic        a_we = 1'b0;
   logic [15:0] cfg = 16'hE003;

   logic        ado, hs, vs, fs;
   logic [7:0]  col;
   logic        d_ado, d_hs, d_vs, d_fs;
   logic [7:0]  d_col;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_frame_display #(
      .TICK_DIV(4), .H_SYNC(HSY), .H_DISP_START(HDS), .H_DISP_END(HDE), .H_TOTAL(HT),
      .V_SYNC(VSY), .V_DISP_START(VDS), .V_DISP_END(VDE), .V_TOTAL(VT)
   ) dut (
      .CLK(clk), .RESET(rst), .A_ADDR(a_addr), .A_DATA_IN(a_din), .A_WE(a_we),
      .A_DATA_OUT(ado), .CONFIG_COLOURS(cfg), .VGA_HS(hs), .VGA_VS(vs),
      .VGA_COLOUR(col), .FRAME_START(fs)
   );

   vga_frame_display u_def (
      .CLK(clk), .RESET(rst), .A_ADDR(a_addr), .A_DATA_IN(a_din), .A_WE(a_we),
      .A_DATA_OUT(d_ado), .CONFIG_COLOURS(cfg), .VGA_HS(d_hs), .VGA_VS(d_vs),
      .VGA_COLOUR(d_col), .FRAME_START(d_fs)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: everything derives from k, the number of clock edges since reset release
   bit   shadow [32768];
   bit   known  [32768];
   int   k = 0;
   bit   pend_pix = 1'b0, pend_known = 1'b0;
   logic exp_hs = 1'b1, exp_vs = 1'b1, exp_fs = 1'b0, exp_ado = 1'b0;
   logic [7:0] exp_col = 8'h00;
   bit   col_known = 1'b1, ado_known = 1'b1;

   function automatic int scan_addr(input int p);
      int hc, vc, hx, vy;
      hc = p % HT;
      vc = (p / HT) % VT;
      hx = (hc - HDS + 1024) % 1024;
      vy = (vc - VDS + 1024) % 1024;
      return ((vy / 4) % 128) * 256 + ((hx / 4) % 256);
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            k = 0; exp_hs = 1'b1; exp_vs = 1'b1; exp_col = 8'h00; col_known = 1'b1;
            exp_fs = 1'b0; exp_ado = 1'b0; ado_known = 1'b1;
         end else begin
            int p, hc, vc, addr, cx, cy;
            bit vis, brd;
            k++;
            exp_ado   = shadow[a_addr];
            ado_known = known[a_addr];
            if (k >= 5 && k % 4 == 1) begin
               addr       = scan_addr((k - 1) / 4);
               pend_pix   = shadow[addr];
               pend_known = known[addr];
            end
            if (a_we) begin
               shadow[a_addr] = a_din;
               known[a_addr]  = 1'b1;
            end
            if (k >= 6 && k % 4 == 2) begin
               p  = (k - 2) / 4;
               hc = p % HT;
               vc = (p / HT) % VT;
               exp_hs = (hc >= HSY);
               exp_vs = (vc >= VSY);
               vis = (hc >= HDS) && (hc < HDE) && (vc >= VDS) && (vc < VDE);
               cx = (hc - HDS) / 4;
               cy = (vc - VDS) / 4;
               brd = 1'b0;
`ifdef VGA_BORDER_EN
               brd = vis && (cx == 0 || cx == 159 || cy == 0 || cy == 119);
`endif
               if (!vis) begin
                  exp_col = 8'h00; col_known = 1'b1;
               end else if (brd) begin
                  exp_col = cfg[15:8]; col_known = 1'b1;
               end else begin
                  exp_col = pend_pix ? cfg[15:8] : cfg[7:0];
                  col_known = pend_known;
               end
            end
            exp_fs = (k >= 4) && (k % 4 == 0) && ((k / 4) % FRAME_TICKS == 0);
         end
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("vga_hs", int'(hs), int'(exp_hs));
         chk("vga_vs", int'(vs), int'(exp_vs));
         chk("frame_start", int'(fs), int'(exp_fs));
         if (col_known) chk("vga_colour", int'(col), int'(exp_col));
         if (ado_known) chk("a_data_out", int'(ado), int'(exp_ado));
      end
   end

   task automatic wr(input logic [14:0] addr, input logic d);
      a_addr = addr; a_din = d; a_we = 1'b1;
      @(negedge clk);
      a_we = 1'b0;
   endtask

   task automatic wait_fs();
      int n = 0;
      while (fs !== 1'b1 && n < 2 * FRAME_CYC) begin
         @(negedge clk);
         n++;
      end
      if (fs !== 1'b1) chk("frame_start_timeout", 0, 1);
   endtask

   // Hand-computed colours at fixed raster positions, relative to FRAME_START
   task automatic lit_frame(input bit full);
      int vcs [10] = '{1, 3, 10, 11, 11, 11, 11, 11, 14, 15};
      int hcs [10] = '{30, 12, 24, 5, 23, 24, 27, 28, 24, 24};
      int exps[10];
      int cur = 0, d;
      exps = '{8'h00, 8'h03, 8'h03, 8'h00, 8'h03, 8'hE0, 8'hE0, 8'h03, 8'hE0, 8'h03};
`ifdef VGA_BORDER_EN
      exps[1] = 8'hE0;
`endif
      wait_fs();
      for (int i = 0; i < 10; i++) begin
         d = 4 * (vcs[i] * HT + hcs[i]) + 2;
         repeat (d - cur) @(negedge clk);
         cur = d;
         if (full || exps[i] == 8'hE0 && i != 1)
            chk($sformatf("lit_colour_v%0d_h%0d", vcs[i], hcs[i]), int'(col), exps[i]);
      end
   endtask

   initial begin
      int n, w;
      repeat (3) @(negedge clk);
      chk("reset_hs", int'(hs), 1);
      chk("reset_vs", int'(vs), 1);
      chk("reset_colour", int'(col), 0);
      rst = 1'b0;

      // Default-timing instance: first sync fall, pulse width and line period
      n = 0;
      do begin @(negedge clk); n++; end while (d_hs !== 1'b0 && n < 20);
      chk("first_hs_fall_clk", n, 6);
      n = 0;
      while (d_hs !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      n = 0;
      while (d_hs !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
      w = 0;
      while (d_hs === 1'b0 && w < 1000) begin @(negedge clk); w++; end
      chk("hs_low_clk", w, 384);
      n = w;
      while (d_hs !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
      chk("line_period_clk", n, 3200);

      // Zero the displayed corner of the buffer, then plant one foreground pixel
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 16; x++)
            wr(15'(y * 256 + x), 1'b0);
      wr(15'h0203, 1'b1);

      // Port A read-before-write
      wr(15'h1234, 1'b0);
      a_addr = 15'h1234; a_din = 1'b1; a_we = 1'b1;
      @(negedge clk);
      chk("porta_same_cycle_old", int'(ado), 0);
      a_we = 1'b0;
      @(negedge clk);
      chk("porta_read_new", int'(ado), 1);

      wait_fs();
      n = 0;
      do begin @(negedge clk); n++; end while (fs !== 1'b1 && n < 2 * FRAME_CYC);
      chk("frame_period_clk", n, FRAME_CYC);
      lit_frame(1'b1);

      // Random writes and colour changes under the per-cycle model
      for (int i = 0; i < 3 * FRAME_CYC; i++) begin
         @(negedge clk);
         a_we   = ($urandom_range(0, 3) == 0);
         a_din  = 1'($urandom);
         a_addr = ($urandom_range(0, 15) == 0) ? 15'($urandom)
                  : 15'($urandom_range(0, 7) * 256 + $urandom_range(0, 15));
         if (a_addr == 15'h0203) a_we = 1'b0;
         if ($urandom_range(0, 199) == 0) cfg = 16'($urandom);
      end
      a_we = 1'b0;

      // Mid-frame reset: asynchronous return to reset values, buffer retained
      wait_fs();
      repeat (4 * 12 * HT + $urandom_range(0, 100)) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreset_hs", int'(hs), 1);
      chk("midreset_vs", int'(vs), 1);
      chk("midreset_colour", int'(col), 0);
      chk("midreset_fs", int'(fs), 0);
      chk("midreset_ado", int'(ado), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cfg = 16'hE003;
      lit_frame(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
